// File: rtl/sparse_chunk_writer.sv
// Compresses each accepted dense beat into (sparsemap, packed nonzero lanes) and issues
// registered SRAM writes addressed by chunk/beat counters. Define SPARSE_STAT_EN for nz_count_o.
module sparse_chunk_writer #(
  parameter int BUS_SIZE       = 8,
  parameter int DAT_SIZE       = 8,
  parameter int WR_DAT_CYC_NUM = 32,
  parameter int CHUNK_NUM      = 64,
  localparam int DW = ($clog2(WR_DAT_CYC_NUM) > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
  localparam int CW = ($clog2(CHUNK_NUM) > 1) ? $clog2(CHUNK_NUM) : 1
`ifdef SPARSE_STAT_EN
  , localparam int NW = $clog2(BUS_SIZE*WR_DAT_CYC_NUM*CHUNK_NUM+1)
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [DW:0]                  cfg_beats_i,
  input  logic [CW:0]                  cfg_chunks_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0] in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [BUS_SIZE-1:0]          sram_wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0] sram_wr_nonzero_data_o,
  output logic                         sram_wr_valid_o,
  output logic [DW-1:0]                sram_wr_dat_count_o,
  output logic [CW-1:0]                sram_wr_chunk_count_o,
  output logic                         busy_o,
  output logic                         finish_o
`ifdef SPARSE_STAT_EN
  , output logic [NW-1:0]              nz_count_o
`endif
);

  localparam int SW = $clog2(BUS_SIZE+1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                      state;
  logic [DW:0]                 beats;
  logic [CW:0]                 chunks;
  logic [DW:0]                 beats_clamp;
  logic [CW:0]                 chunks_clamp;
  logic [DW-1:0]               dat_cnt;
  logic [CW-1:0]               chunk_cnt;
  logic                        accept;
  logic                        dat_last;
  logic                        chunk_last;
  logic [BUS_SIZE-1:0]         pack_map;
  logic [BUS_SIZE*DAT_SIZE-1:0] pack_data;
  logic [SW-1:0]               slot;
  logic [DAT_SIZE-1:0]         lane;

  always_comb begin
    beats_clamp  = (cfg_beats_i > (DW+1)'(WR_DAT_CYC_NUM)) ? (DW+1)'(WR_DAT_CYC_NUM) : cfg_beats_i;
    chunks_clamp = (cfg_chunks_i > (CW+1)'(CHUNK_NUM)) ? (CW+1)'(CHUNK_NUM) : cfg_chunks_i;
    accept       = in_valid_i && in_ready_o;
    dat_last     = ({1'b0, dat_cnt} == beats - (DW+1)'(1));
    chunk_last   = ({1'b0, chunk_cnt} == chunks - (CW+1)'(1));
  end

  // slot ends as the number of nonzero lanes, which doubles as the popcount
  always_comb begin
    pack_map  = '0;
    pack_data = '0;
    slot      = '0;
    lane      = '0;
    for (int unsigned k = 0; k < BUS_SIZE; k++) begin
      lane = in_data_i[k*DAT_SIZE +: DAT_SIZE];
      if (lane != '0) begin
        pack_map[k] = 1'b1;
        pack_data[slot*DAT_SIZE +: DAT_SIZE] = lane;
        slot = slot + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state                  <= IDLE;
      beats                  <= '0;
      chunks                 <= '0;
      dat_cnt                <= '0;
      chunk_cnt              <= '0;
      in_ready_o             <= 1'b0;
      sram_wr_sparsemap_o    <= '0;
      sram_wr_nonzero_data_o <= '0;
      sram_wr_valid_o        <= 1'b0;
      sram_wr_dat_count_o    <= '0;
      sram_wr_chunk_count_o  <= '0;
      busy_o                 <= 1'b0;
      finish_o               <= 1'b0;
`ifdef SPARSE_STAT_EN
      nz_count_o             <= '0;
`endif
    end else begin
      sram_wr_valid_o <= 1'b0;
      finish_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            beats     <= beats_clamp;
            chunks    <= chunks_clamp;
            dat_cnt   <= '0;
            chunk_cnt <= '0;
            busy_o    <= 1'b1;
`ifdef SPARSE_STAT_EN
            nz_count_o <= '0;
`endif
            if (beats_clamp == '0 || chunks_clamp == '0) begin
              state    <= DONE;
              finish_o <= 1'b1;
            end else begin
              state      <= RUN;
              in_ready_o <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            sram_wr_valid_o        <= 1'b1;
            sram_wr_sparsemap_o    <= pack_map;
            sram_wr_nonzero_data_o <= pack_data;
            sram_wr_dat_count_o    <= dat_cnt;
            sram_wr_chunk_count_o  <= chunk_cnt;
`ifdef SPARSE_STAT_EN
            nz_count_o <= nz_count_o + NW'(slot);
`endif
            if (dat_last && chunk_last) begin
              state      <= FLUSH;
              in_ready_o <= 1'b0;
            end else if (dat_last) begin
              dat_cnt   <= '0;
              chunk_cnt <= chunk_cnt + CW'(1);
            end else begin
              dat_cnt <= dat_cnt + DW'(1);
            end
          end
        end
        FLUSH: begin
          state    <= DONE;
          finish_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
